// File: rtl/aes_byte_stream_adapter.sv
`default_nettype none
// ============================================================================
//  Module   : aes_byte_stream_adapter
//  Purpose  : Byte-serial load/unload wrapper around a combinational AES-128
//             encryption core, with key retention across blocks.
//  Revision : 1.0 - initial release
// ============================================================================
module aes_byte_stream_adapter #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_byte,
  input  logic         in_is_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_byte,
  output logic [127:0] blk_data,
  output logic [127:0] blk_key,
  input  logic [127:0] blk_result,
  output logic         busy,
  output logic         key_loaded,
  output logic         err
);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_OUTPUT = 2'd2
  } state_t;

  localparam logic [3:0] c_settle_last = 4'(SETTLE_CYCLES - 1);

  state_t         r_state;
  state_t         w_state_next;
  logic [3:0]     r_key_cnt;
  logic [3:0]     r_data_cnt;
  logic [3:0]     r_settle_cnt;
  logic [3:0]     r_out_cnt;
  logic [127:0]   r_shift;
  logic [127:0]   r_blk_data;
  logic [127:0]   r_blk_key;
  logic           r_out_valid;
  logic           r_key_loaded;
  logic           r_err;

  logic           w_in_acc;
  logic           w_key_ok;
  logic           w_data_ok;
  logic           w_proto_err;
  logic           w_capture;
  logic           w_out_xfer;

  // A byte offered during clear is never taken, even though in_ready is high.
  assign w_in_acc    = in_valid & in_ready & ~clear;
  assign w_key_ok    = w_in_acc & in_is_key & (r_data_cnt == 4'd0);
  assign w_data_ok   = w_in_acc & ~in_is_key & r_key_loaded;
  assign w_proto_err = w_in_acc & ~w_key_ok & ~w_data_ok;
  assign w_capture   = (r_state == ST_SETTLE) & (r_settle_cnt == c_settle_last);
  assign w_out_xfer  = (r_state == ST_OUTPUT) & r_out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = (r_state == ST_LOAD);
    busy         = (r_state == ST_SETTLE) | (r_state == ST_OUTPUT);
    case (r_state)
      ST_LOAD:   if (w_data_ok && (r_data_cnt == 4'd15)) w_state_next = ST_SETTLE;
      ST_SETTLE: if (w_capture) w_state_next = ST_OUTPUT;
      ST_OUTPUT: if (w_out_xfer && (r_out_cnt == 4'd15)) w_state_next = ST_LOAD;
      default:   w_state_next = ST_LOAD;
    endcase
    if (clear) begin
      w_state_next = ST_LOAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_cnt    <= 4'd0;
      r_data_cnt   <= 4'd0;
      r_settle_cnt <= 4'd0;
      r_out_cnt    <= 4'd0;
      r_shift      <= 128'd0;
      r_blk_data   <= 128'd0;
      r_blk_key    <= 128'd0;
      r_out_valid  <= 1'b0;
      r_key_loaded <= 1'b0;
      r_err        <= 1'b0;
    end else if (clear) begin
      // Key and block registers are left as-is; the next load overwrites them.
      r_key_cnt    <= 4'd0;
      r_data_cnt   <= 4'd0;
      r_settle_cnt <= 4'd0;
      r_out_cnt    <= 4'd0;
      r_out_valid  <= 1'b0;
      r_key_loaded <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      if (w_proto_err) begin
        r_err <= 1'b1;
      end

      if (w_key_ok) begin
        r_blk_key[7'd127 - {r_key_cnt, 3'b000} -: 8] <= in_byte;
        if (r_key_cnt == 4'd0) begin
          r_key_loaded <= 1'b0;
        end
        if (r_key_cnt == 4'd15) begin
          r_key_cnt    <= 4'd0;
          r_key_loaded <= 1'b1;
        end else begin
          r_key_cnt <= r_key_cnt + 4'd1;
        end
      end

      if (w_data_ok) begin
        r_blk_data[7'd127 - {r_data_cnt, 3'b000} -: 8] <= in_byte;
        if (r_data_cnt == 4'd15) begin
          r_data_cnt   <= 4'd0;
          r_settle_cnt <= 4'd0;
        end else begin
          r_data_cnt <= r_data_cnt + 4'd1;
        end
      end

      if (r_state == ST_SETTLE) begin
        r_settle_cnt <= r_settle_cnt + 4'd1;
        if (w_capture) begin
          r_shift     <= blk_result;
          r_out_valid <= 1'b1;
        end
      end

      if (w_out_xfer) begin
        r_shift <= {r_shift[119:0], 8'h00};
        if (r_out_cnt == 4'd15) begin
          r_out_cnt   <= 4'd0;
          r_out_valid <= 1'b0;
        end else begin
          r_out_cnt <= r_out_cnt + 4'd1;
        end
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_byte   = r_shift[127:120];
  assign blk_data   = r_blk_data;
  assign blk_key    = r_blk_key;
  assign key_loaded = r_key_loaded;
  assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_aes_byte_stream_adapter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aes_byte_stream_adapter
//  Purpose  : Self-checking bench with a behavioural AES-128 core model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_aes_byte_stream_adapter;

  localparam int SETTLE = 2;

  logic         clk = 1'b0;
  logic         rst_n, clear, in_valid, in_is_key, out_ready;
  logic [7:0]   in_byte;
  logic         in_ready, out_valid, busy, key_loaded, err;
  logic [7:0]   out_byte;
  logic [127:0] blk_data, blk_key, blk_result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aes_byte_stream_adapter #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte), .in_is_key(in_is_key),
    .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
    .blk_data(blk_data), .blk_key(blk_key), .blk_result(blk_result),
    .busy(busy), .key_loaded(key_loaded), .err(err)
  );

  // ---------------- behavioural AES-128 (FIPS-197) ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00; aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv, base;
    logic [7:0] e;
    inv = 8'h01; base = x; e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) inv = gmul(inv, base);
      base = gmul(base, base);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes128(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [31:0]  tmp;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox(tmp[31:24]), sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0])} ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int n = 0; n < 16; n++) s[n] = pt[127 - 8*n -: 8] ^ w[n/4][31 - 8*(n%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int n = 0; n < 16; n++) t[n] = sbox(s[n]);
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) s[rr + 4*c] = t[rr + 4*((c + rr) % 4)];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
          s[4*c+3] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
        end
      end
      for (int n = 0; n < 16; n++) s[n] = s[n] ^ w[4*r + n/4][31 - 8*(n%4) -: 8];
    end
    for (int n = 0; n < 16; n++) res[127 - 8*n -: 8] = s[n];
    return res;
  endfunction

  assign blk_result = aes128(blk_key, blk_data);

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic k);
    int waitc;
    waitc = 0;
    in_valid = 1'b1; in_byte = b; in_is_key = k;
    while (!in_ready && waitc < 100) begin tick(); waitc++; end
    if (!in_ready) chk("in_ready_timeout", 128'(in_ready), 128'd1);
    else tick();
    in_valid = 1'b0;
  endtask

  task automatic send_vec(input logic [127:0] v, input logic k, input int first, input int last);
    for (int i = first; i <= last; i++) send_byte(v[127 - 8*i -: 8], k);
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0, 2: random
  task automatic recv_block(input int mode, output logic [127:0] ct);
    int cyc, got;
    logic [7:0] held;
    logic stalled;
    cyc = 0; got = 0; ct = '0; stalled = 1'b0; held = 8'h00;
    while (got < 16 && cyc < 400) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0);
        default: out_ready = 1'($urandom % 2);
      endcase
      if (stalled) begin
        chk("stall_valid", 128'(out_valid), 128'd1);
        chk("stall_byte", 128'(out_byte), 128'(held));
      end
      if (out_valid && out_ready) begin
        ct[127 - 8*got -: 8] = out_byte;
        got++;
      end
      stalled = out_valid && !out_ready;
      held = out_byte;
      tick(); cyc++;
    end
    out_ready = 1'b0;
    chk("recv_count", 128'(got), 128'd16);
  endtask

  task automatic finish_block(input string name, input logic [127:0] exp, input int mode);
    logic [127:0] ct;
    chk({name, "_busy"}, 128'(busy), 128'd1);
    for (int k = 0; k < SETTLE; k++) begin
      chk({name, "_early_valid"}, 128'(out_valid), 128'd0);
      tick();
    end
    chk({name, "_latency_valid"}, 128'(out_valid), 128'd1);
    recv_block(mode, ct);
    chk({name, "_ct"}, ct, exp);
    chk({name, "_in_ready_after"}, 128'(in_ready), 128'd1);
    chk({name, "_busy_after"}, 128'(busy), 128'd0);
  endtask

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
    bit           load;
    int           mode;
  } vec_t;

  vec_t vt [5];

  logic [7:0]   mkey [16];
  logic [7:0]   mdat [16];
  int           kcnt, dcnt;
  bit           mloaded, merr;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [127:0] kv, dv, part;
    logic         isk, done;
    logic [7:0]   b;
    int           u, vcount;

    vt[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
              128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1, 0};
    vt[1] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
              128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0, 0};
    vt[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
              128'h3925841d02dc09fbdc118597196a0b32, 1'b1, 1};
    vt[3] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h6bc1bee22e409f96e93d7e117393172a,
              128'h3ad77bb40d7a3660a89ecaf32466ef97, 1'b1, 0};
    vt[4] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
              128'hf5d3d58503b9699de785895a96fdbaaf, 1'b0, 2};

    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_is_key = 1'b0; in_byte = 8'h00; out_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_key_loaded", 128'(key_loaded), 128'd0);
    chk("rst_err", 128'(err), 128'd0);
    chk("rst_out_byte", 128'(out_byte), 128'd0);
    chk("rst_blk_data", blk_data, 128'd0);
    chk("rst_blk_key", blk_key, 128'd0);

    // Data byte with no key: dropped and flagged; the following block must still align.
    send_byte(8'h55, 1'b0);
    chk("nokey_err", 128'(err), 128'd1);
    chk("nokey_busy", 128'(busy), 128'd0);

    foreach (vt[i]) begin
      if (vt[i].load) begin
        send_vec(vt[i].key, 1'b1, 0, 15);
        chk($sformatf("vec%0d_key_loaded", i), 128'(key_loaded), 128'd1);
      end
      send_vec(vt[i].pt, 1'b0, 0, 15);
      chk($sformatf("vec%0d_key_kept", i), 128'(key_loaded), 128'd1);
      chk($sformatf("vec%0d_blk_key", i), blk_key, vt[i].key);
      chk($sformatf("vec%0d_blk_data", i), blk_data, vt[i].pt);
      finish_block($sformatf("vec%0d", i), vt[i].ct, vt[i].mode);
    end
    chk("err_sticky", 128'(err), 128'd1);

    pulse_clear();
    chk("clear_err", 128'(err), 128'd0);
    chk("clear_key_loaded", 128'(key_loaded), 128'd0);

    // Key byte mid-block is dropped; the block completes with the original key.
    send_vec(vt[0].key, 1'b1, 0, 15);
    send_vec(vt[0].pt, 1'b0, 0, 4);
    send_byte(8'haa, 1'b1);
    chk("midkey_err", 128'(err), 128'd1);
    send_vec(vt[0].pt, 1'b0, 5, 15);
    chk("midkey_blk_key", blk_key, vt[0].key);
    finish_block("midkey", vt[0].ct, 0);

    // Clear after a partial key; a byte offered in the clear cycle must be ignored.
    send_vec(vt[2].key, 1'b1, 0, 7);
    chk("partkey_loaded", 128'(key_loaded), 128'd0);
    in_valid = 1'b1; in_is_key = 1'b1; in_byte = 8'hee;
    pulse_clear();
    in_valid = 1'b0;
    chk("pclear_key_loaded", 128'(key_loaded), 128'd0);
    chk("pclear_err", 128'(err), 128'd0);
    chk("pclear_in_ready", 128'(in_ready), 128'd1);
    send_vec(vt[2].key, 1'b1, 0, 15);
    send_vec(vt[2].pt, 1'b0, 0, 15);
    finish_block("after_clear", vt[2].ct, 0);

    // Randomized traffic against the transaction-level model.
    pulse_clear();
    kcnt = 0; dcnt = 0; mloaded = 1'b0; merr = 1'b0;
    for (int trial = 0; trial < 12; trial++) begin
      if ($urandom % 4 == 0) begin
        pulse_clear();
        kcnt = 0; dcnt = 0; mloaded = 1'b0; merr = 1'b0;
      end
      done = 1'b0; vcount = 0;
      while (!done && vcount < 300) begin
        u = int'($urandom % 100);
        if (!mloaded && kcnt > 0) isk = (u < 95);
        else if (!mloaded)        isk = (u < 90);
        else if (dcnt == 0)       isk = (u < 10);
        else                      isk = (u < 7);
        b = 8'($urandom);
        send_byte(b, isk);
        vcount++;
        if (isk) begin
          if (dcnt == 0) begin
            if (kcnt == 0) mloaded = 1'b0;
            mkey[kcnt] = b;
            kcnt++;
            if (kcnt == 16) begin kcnt = 0; mloaded = 1'b1; end
          end else begin
            merr = 1'b1;
          end
        end else if (!mloaded) begin
          merr = 1'b1;
        end else begin
          mdat[dcnt] = b;
          dcnt++;
          if (dcnt == 16) begin dcnt = 0; done = 1'b1; end
        end
      end
      for (int n = 0; n < 16; n++) begin
        kv[127 - 8*n -: 8] = mkey[n];
        dv[127 - 8*n -: 8] = mdat[n];
      end
      chk($sformatf("rnd%0d_done", trial), 128'(done), 128'd1);
      chk($sformatf("rnd%0d_blk_key", trial), blk_key, kv);
      chk($sformatf("rnd%0d_blk_data", trial), blk_data, dv);
      chk($sformatf("rnd%0d_err", trial), 128'(err), 128'(merr));
      chk($sformatf("rnd%0d_key_loaded", trial), 128'(key_loaded), 128'(mloaded));
      finish_block($sformatf("rnd%0d", trial), aes128(kv, dv), 2);
    end

    // Asynchronous reset in the middle of ciphertext output.
    send_vec(vt[3].key, 1'b1, 0, 15);
    send_vec(vt[3].pt, 1'b0, 0, 15);
    repeat (SETTLE) tick();
    out_ready = 1'b1;
    part = '0;
    for (int i = 0; i < 4; i++) begin
      part[127 - 8*i -: 8] = out_byte;
      tick();
    end
    chk("arst_first4", part[127:96], vt[3].ct[127:96]);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 128'(out_valid), 128'd0);
    chk("arst_busy", 128'(busy), 128'd0);
    chk("arst_key_loaded", 128'(key_loaded), 128'd0);
    tick();
    rst_n = 1'b1;
    u = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) u++;
      tick();
    end
    out_ready = 1'b0;
    chk("arst_no_output", 128'(u), 128'd0);
    chk("arst_in_ready", 128'(in_ready), 128'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aes_byte_stream_adapter.md
Name: aes_byte_stream_adapter

Overview:
Byte-serial front/back end for the combinational AES-128 encryption core. Collects a 16-byte key and 16-byte plaintext blocks from a valid/ready byte stream and holds them stable on the core's inputs. After a fixed settle window it captures the 128-bit ciphertext and streams it back out byte-serially. The key is retained across blocks, so a new key is loaded only when it changes.

Parameters:
SETTLE_CYCLES, 2, cycles allowed for the combinational core to settle before capture; legal range 1..15.

Ports:
clk  input  1  system clock; all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous pulse: abort current operation, forget key, clear err
in_valid  input  1  input byte valid
in_ready  output  1  adapter can accept an input byte
in_byte  input  8  input byte
in_is_key  input  1  1 = key byte, 0 = plaintext byte; qualified by in_valid
out_valid  output  1  ciphertext byte valid
out_ready  input  1  downstream accepts ciphertext byte
out_byte  output  8  ciphertext byte
blk_data  output  128  plaintext to core
blk_key  output  128  key to core
blk_result  input  128  ciphertext from core
busy  output  1  high in SETTLE or OUTPUT
key_loaded  output  1  full 16-byte key present
err  output  1  sticky protocol-error flag

Behaviour:
- Reset (rst_n low, asynchronous): state LOAD; key_cnt=0, data_cnt=0, settle_cnt=0; key_loaded=0, err=0, out_valid=0, out_byte=0x00, blk_data=0, blk_key=0, busy=0. in_ready=1 once rst_n is high.
- Byte order: first byte received → bits [127:120], 16th → [7:0]. Same order on output.
- Input handshake: byte accepted on a rising edge with in_valid & in_ready. in_ready = (state==LOAD).
- States:
  - LOAD:
    - Key byte accepted with data_cnt==0: if key_cnt==0, key_loaded←0 (new key begins). Byte is written into blk_key at slot key_cnt; key_cnt++. On the 16th key byte: key_cnt←0, key_loaded←1.
    - Key byte accepted with data_cnt!=0: dropped, err←1, no counter change.
    - Data byte accepted with key_loaded==0 (includes a partially loaded key): dropped, err←1.
    - Otherwise the data byte is written into blk_data at slot data_cnt; data_cnt++. On the 16th data byte: data_cnt←0, settle_cnt←0, go to SETTLE.
  - SETTLE: settle_cnt increments each cycle. At the edge where settle_cnt==SETTLE_CYCLES-1, load the output shift register from blk_result, out_valid←1, go to OUTPUT.
    - out_valid rises exactly SETTLE_CYCLES cycles after the edge accepting the 16th data byte.
  - OUTPUT: out_byte = shift register [127:120].
    - On out_valid & out_ready: shift left 8 and increment out_cnt.
    - On the 16th transfer: out_valid←0, out_cnt←0, go to LOAD. in_ready is high in the next cycle.
    - out_byte and out_valid are held stable while out_ready is low.
- blk_data and blk_key change only on accepted LOAD bytes. They are stable throughout SETTLE and OUTPUT.
- busy = (state==SETTLE) | (state==OUTPUT).
- clear: synchronous, highest priority below reset, effective in any state.
  - Effect: state←LOAD; all counters←0; key_loaded←0; err←0; out_valid←0.
  - blk_key and blk_data keep their contents but are overwritten by the next load.
  - A byte presented in the clear cycle is not accepted.
- Reset mid-operation: returns immediately to reset values; any partial key, partial block or in-flight ciphertext is discarded.
- Simultaneous events: in LOAD, out_valid is 0, so input and output transfers are never both active in one cycle. Throughput is one block per 16 + SETTLE_CYCLES + 16 cycles minimum.

Test Plan:
- FIPS-197 vector: key bytes 00 01 … 0f, then plaintext 00 11 22 … ff, out_ready=1 → out_valid exactly 2 cycles after the 16th data accept; bytes 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a; in_ready=1 the cycle after the last byte.
- Key reuse: second plaintext 00 11 … ff without reloading the key → same ciphertext; key_loaded stays 1 throughout.
- Backpressure: out_ready toggled 1,0,0,1… → each byte held stable while stalled; no byte lost or duplicated; all 16 bytes correct.
- Protocol errors:
  - Data byte before any key → dropped, err=1, data_cnt=0.
  - Key byte after 5 data bytes → dropped, err=1; remaining 11 data bytes still complete the block correctly.
- clear after 8 key bytes → key_loaded=0, err=0, in_ready=1; subsequent full key + plaintext yields the correct ciphertext.
- Asynchronous reset asserted mid-OUTPUT after 4 bytes → out_valid=0, busy=0, key_loaded=0 immediately; no further output bytes after release.
